frog_life_ctrl: RTL
===================

Name: frog_life_ctrl

Overview:
- Game-state stage directly downstream of the frog/car collision checker; consumes its registered collision flag.
- Tracks lives and score, sequences death freeze, respawn, post-respawn invulnerability and game over.
- Drives the frog movement block (respawn, freeze) and the HUD/renderer (lives, score, state flags).

Parameters:
- START_LIVES, 3, lives loaded at reset and at game start; 1..7.
- HIT_FRAMES, 60, frame ticks spent frozen after a hit; >=1.
- GRACE_FRAMES, 90, frame ticks of invulnerability after a respawn; >=1.
- GOAL_Y_MAX, 31, a frog Y <= this value is the goal row.
- SCORE_W, 8, score width.

Ports:
- i_Clk  in  1  system clock (pixel clock domain)
- i_Rst  in  1  synchronous, active-high reset
- i_Has_Collided  in  1  level collision flag from the collision checker
- i_Frame_Tick  in  1  one-cycle pulse per video frame
- i_Start  in  1  start request, debounced, one-cycle pulse
- i_Frog_Y  in  10  frog top-left Y
- o_Lives  out  3  remaining lives
- o_Score  out  SCORE_W  goal crossings this game
- o_Respawn  out  1  one-cycle pulse: frog returns to spawn tile
- o_Freeze  out  1  frog movement disabled
- o_Invulnerable  out  1  high in GRACE
- o_Game_Over  out  1  high in GAME_OVER
- o_State  out  3  state encoding, debug/HUD

Behaviour:
- All outputs registered. Reset (i_Rst high at a clock edge): state IDLE, o_Lives=START_LIVES, o_Score=0, o_Respawn=0, o_Freeze=1, o_Invulnerable=0, o_Game_Over=0, frame counter 0. Reset wins over every other input on the same edge, in any state.
- State encodings: IDLE=0, PLAY=1, HIT=2, GRACE=3, GAME_OVER=4.
- IDLE: o_Freeze=1. On i_Start go to GRACE, lives=START_LIVES, score=0, pulse o_Respawn, counter=GRACE_FRAMES.
- PLAY: o_Freeze=0.
  - Goal: i_Frog_Y<=GOAL_Y_MAX. Score+1, saturating at 2^SCORE_W-1. Pulse o_Respawn. Go to GRACE with counter=GRACE_FRAMES.
  - Collision: i_Has_Collided=1. If o_Lives==1, set lives=0 and go to GAME_OVER. Otherwise lives-1 and go to HIT with counter=HIT_FRAMES.
  - Goal and collision in the same cycle: goal wins, no life lost.
- HIT: o_Freeze=1. i_Has_Collided and goal are ignored.
  - Each i_Frame_Tick decrements the counter.
  - A tick with counter==1 pulses o_Respawn and enters GRACE with counter=GRACE_FRAMES.
  - Exactly HIT_FRAMES ticks are spent in HIT. A tick on the entry edge is not counted.
- GRACE: o_Freeze=0, o_Invulnerable=1. Collisions are ignored.
  - Goal behaves as in PLAY: score+1, o_Respawn, counter reloaded to GRACE_FRAMES, stay in GRACE.
  - Otherwise a tick with counter==1 goes to PLAY.
- GAME_OVER: o_Freeze=1, o_Game_Over=1, o_Lives=0, score held. i_Start behaves as in IDLE.
- o_Respawn: high for exactly one cycle per event. It is asserted on the same edge as the state change.
- i_Start: ignored in PLAY, HIT and GRACE.
- Lives never underflow. Score never wraps.
- Illegal state encodings return to IDLE on the next edge.
- Latency: a collision present at edge N is reflected in o_Lives/o_State after edge N, i.e. visible in cycle N+1.

Test Plan:
- Reset, then i_Start pulse -> o_Respawn high 1 cycle. State=3, o_Invulnerable=1, o_Lives=3, o_Score=0. After 90 ticks state=1.
- In PLAY assert i_Has_Collided -> next cycle o_Lives=2, state=2, o_Freeze=1. Collision held for 60 ticks causes no further loss. The 60th tick gives o_Respawn pulse and state=3.
- In GRACE hold i_Has_Collided for 90 ticks -> o_Lives unchanged, state returns to 1 after the 90th tick.
- Three collisions across the PLAY phases -> o_Lives 3->2->1->0. The third goes straight to state=4 with o_Game_Over=1 and no respawn. i_Start then gives o_Lives=3, o_Score=0, state=3.
- In PLAY set i_Frog_Y=20 with i_Has_Collided=1 on the same cycle -> o_Score+1, o_Lives unchanged, o_Respawn pulse, state=3.
- SCORE_W=2: four goals -> o_Score 1,2,3,3. Assert i_Rst mid-HIT -> state=0, o_Lives=3, o_Score=0, o_Freeze=1.

Source files
------------

// File: rtl/frog_life_ctrl.sv
// Game-state controller for the frog: lives, score, death freeze,
// respawn, post-respawn invulnerability and game over.
module frog_life_ctrl #(
    parameter int unsigned START_LIVES  = 3,
    parameter int unsigned HIT_FRAMES   = 60,
    parameter int unsigned GRACE_FRAMES = 90,
    parameter int unsigned GOAL_Y_MAX   = 31,
    parameter int unsigned SCORE_W      = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Has_Collided,
    input  logic               i_Frame_Tick,
    input  logic               i_Start,
    input  logic [9:0]         i_Frog_Y,
    output logic [2:0]         o_Lives,
    output logic [SCORE_W-1:0] o_Score,
    output logic               o_Respawn,
    output logic               o_Freeze,
    output logic               o_Invulnerable,
    output logic               o_Game_Over,
    output logic [2:0]         o_State
);

    localparam int unsigned MAX_FRAMES = (HIT_FRAMES > GRACE_FRAMES) ? HIT_FRAMES : GRACE_FRAMES;
    localparam int unsigned CNT_W      = $clog2(MAX_FRAMES + 1);

    localparam logic [CNT_W-1:0]   HIT_LOAD   = CNT_W'(HIT_FRAMES);
    localparam logic [CNT_W-1:0]   GRACE_LOAD = CNT_W'(GRACE_FRAMES);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]         LIVES_INIT = 3'(START_LIVES);
    localparam logic [9:0]         GOAL_Y     = 10'(GOAL_Y_MAX);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_HIT       = 3'd2,
        S_GRACE     = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    state_t             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [2:0]         lives_q,   lives_d;
    logic [SCORE_W-1:0] score_q,   score_d;
    logic               respawn_q, respawn_d;
    logic               freeze_q,  freeze_d;
    logic               inv_q,     inv_d;
    logic               go_q,      go_d;

    logic               goal;
    logic [SCORE_W-1:0] score_sat;

    // Goal row detection and saturating score increment.
    always_comb begin
        goal      = (i_Frog_Y <= GOAL_Y);
        score_sat = (score_q == SCORE_MAX) ? score_q : (score_q + SCORE_ONE);
    end

    // Next-state, counter, lives/score and registered-output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lives_d   = lives_q;
        score_d   = score_q;
        respawn_d = 1'b0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (i_Start) begin
                    state_d   = S_GRACE;
                    lives_d   = LIVES_INIT;
                    score_d   = '0;
                    respawn_d = 1'b1;
                    cnt_d     = GRACE_LOAD;
                end
            end
            S_PLAY: begin
                // Goal takes priority over a same-cycle collision.
                if (goal) begin
                    state_d   = S_GRACE;
                    score_d   = score_sat;
                    respawn_d = 1'b1;
                    cnt_d     = GRACE_LOAD;
                end else if (i_Has_Collided) begin
                    if (lives_q <= 3'd1) begin
                        lives_d = '0;
                        state_d = S_GAME_OVER;
                    end else begin
                        lives_d = lives_q - 3'd1;
                        state_d = S_HIT;
                        cnt_d   = HIT_LOAD;
                    end
                end
            end
            S_HIT: begin
                if (i_Frame_Tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d   = S_GRACE;
                        respawn_d = 1'b1;
                        cnt_d     = GRACE_LOAD;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            S_GRACE: begin
                if (goal) begin
                    score_d   = score_sat;
                    respawn_d = 1'b1;
                    cnt_d     = GRACE_LOAD;
                end else if (i_Frame_Tick) begin
                    if (cnt_q <= CNT_ONE) begin
                        state_d = S_PLAY;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flags follow the state being entered so they line up with o_State.
        freeze_d = (state_d == S_IDLE) || (state_d == S_HIT) || (state_d == S_GAME_OVER);
        inv_d    = (state_d == S_GRACE);
        go_d     = (state_d == S_GAME_OVER);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            lives_q   <= LIVES_INIT;
            score_q   <= '0;
            respawn_q <= 1'b0;
            freeze_q  <= 1'b1;
            inv_q     <= 1'b0;
            go_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lives_q   <= lives_d;
            score_q   <= score_d;
            respawn_q <= respawn_d;
            freeze_q  <= freeze_d;
            inv_q     <= inv_d;
            go_q      <= go_d;
        end
    end

    assign o_Lives        = lives_q;
    assign o_Score        = score_q;
    assign o_Respawn      = respawn_q;
    assign o_Freeze       = freeze_q;
    assign o_Invulnerable = inv_q;
    assign o_Game_Over    = go_q;
    assign o_State        = state_q;

endmodule
